// File: rtl/ga_init_pop_mc.sv
// rtl/ga_init_pop_mc.sv - initial-population generator, WPC weights per fill cycle
// Builds cnfg_p chromosomes of cnfg_m weights and pushes each into the chromosome queue.
module ga_init_pop_mc #(
   parameter int DATA_W      = 6,
   parameter int M_MAX       = 32,
   parameter int P_MAX       = 1024,
   parameter int RAND_W      = 42,
   parameter int WPC         = RAND_W / DATA_W,
   parameter int P_MAX_W     = $clog2(P_MAX + 1),
   parameter int M_MAX_W     = $clog2(M_MAX + 1),
   parameter int CHROM_MAX_W = DATA_W * M_MAX
) (
   input  logic                   clk,
   input  logic                   rstn,
   input  logic                   sw_rst,
   input  logic [P_MAX_W-1:0]     cnfg_p,
   input  logic [M_MAX_W-1:0]     cnfg_m,
   input  logic [1:0]             cnfg_mode,
   input  logic [CHROM_MAX_W-1:0] cnfg_seed_chrom,
   input  logic                   start_pls,
   input  logic [RAND_W-1:0]      rand_data,
   input  logic                   queue_ready,
   output logic                   queue_push,
   output logic [CHROM_MAX_W-1:0] queue_chromosome,
   output logic                   busy,
   output logic                   done_pls
);

   localparam int IDX_W = $clog2(M_MAX + WPC + 1);

   typedef enum logic [1:0] {IDLE, FILL, PUSH} state_e;

   state_e                 state_q;
   logic [P_MAX_W-1:0]     p_q;
   logic [P_MAX_W-1:0]     cnt_q;
   logic [M_MAX_W-1:0]     m_q;
   logic [M_MAX_W-1:0]     m_clamp;
   logic [1:0]             mode_q;
   logic [CHROM_MAX_W-1:0] seed_q;
   logic [CHROM_MAX_W-1:0] chrom_q;
   logic [CHROM_MAX_W-1:0] chrom_seed_d;
   logic [CHROM_MAX_W-1:0] chrom_fill_d;
   logic [IDX_W-1:0]       widx_q;
   logic                   busy_q;
   logic                   done_q;

   always_comb begin
      m_clamp = (cnfg_m > M_MAX_W'(M_MAX)) ? M_MAX_W'(M_MAX) : cnfg_m;
   end

   // Seed chromosome with weights at or beyond cnfg_m zeroed.
   always_comb begin
      chrom_seed_d = '0;
      for (int i = 0; i < M_MAX; i++) begin
         if (i < int'(m_clamp)) begin
            chrom_seed_d[i*DATA_W +: DATA_W] = cnfg_seed_chrom[i*DATA_W +: DATA_W];
         end
      end
   end

   // Weight w_idx+k takes random slice k; perturb mode flips the seed's two LSBs.
   always_comb begin
      chrom_fill_d = chrom_q;
      for (int k = 0; k < WPC; k++) begin
         if (int'(widx_q) + k < M_MAX) begin
            if (int'(widx_q) + k < int'(m_q)) begin
               if (mode_q == 2'd2) begin
                  chrom_fill_d[(int'(widx_q) + k)*DATA_W +: DATA_W] =
                     seed_q[(int'(widx_q) + k)*DATA_W +: DATA_W] ^
                     DATA_W'(rand_data[k*DATA_W +: 2]);
               end else begin
                  chrom_fill_d[(int'(widx_q) + k)*DATA_W +: DATA_W] =
                     rand_data[k*DATA_W +: DATA_W];
               end
            end else begin
               chrom_fill_d[(int'(widx_q) + k)*DATA_W +: DATA_W] = '0;
            end
         end
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         state_q <= IDLE;
         p_q     <= '0;
         cnt_q   <= '0;
         m_q     <= '0;
         mode_q  <= '0;
         seed_q  <= '0;
         chrom_q <= '0;
         widx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else if (sw_rst) begin
         state_q <= IDLE;
         p_q     <= '0;
         cnt_q   <= '0;
         m_q     <= '0;
         mode_q  <= '0;
         seed_q  <= '0;
         chrom_q <= '0;
         widx_q  <= '0;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (state_q)
            IDLE: begin
               if (start_pls) begin
                  p_q    <= cnfg_p;
                  m_q    <= m_clamp;
                  mode_q <= cnfg_mode;
                  seed_q <= cnfg_seed_chrom;
                  cnt_q  <= '0;
                  widx_q <= '0;
                  if (cnfg_p == '0) begin
                     done_q <= 1'b1;
                  end else begin
                     busy_q <= 1'b1;
                     if (cnfg_mode == 2'd1) begin
                        chrom_q <= chrom_seed_d;
                        state_q <= PUSH;
                     end else begin
                        chrom_q <= '0;
                        state_q <= FILL;
                     end
                  end
               end
            end
            FILL: begin
               chrom_q <= chrom_fill_d;
               widx_q  <= widx_q + IDX_W'(WPC);
               if (int'(widx_q) + WPC >= int'(m_q)) begin
                  state_q <= PUSH;
               end
            end
            PUSH: begin
               if (queue_ready) begin
                  if (cnt_q == p_q - P_MAX_W'(1)) begin
                     state_q <= IDLE;
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                  end else begin
                     cnt_q   <= cnt_q + P_MAX_W'(1);
                     chrom_q <= '0;
                     widx_q  <= '0;
                     state_q <= FILL;
                  end
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign queue_push       = (state_q == PUSH) && queue_ready;
   assign queue_chromosome = chrom_q;
   assign busy             = busy_q;
   assign done_pls         = done_q;

endmodule

// File: tb/tb_ga_init_pop_mc.sv
// tb/tb_ga_init_pop_mc.sv - table-driven bench for ga_init_pop_mc
module tb_ga_init_pop_mc;

   localparam int CW = 192;

   logic            clk;
   logic            rstn;
   logic            sw_rst;
   logic [10:0]     cnfg_p;
   logic [5:0]      cnfg_m;
   logic [1:0]      cnfg_mode;
   logic [CW-1:0]   cnfg_seed_chrom;
   logic            start_pls;
   logic [41:0]     rand_data;
   logic            queue_ready;
   logic            queue_push;
   logic [CW-1:0]   queue_chromosome;
   logic            busy;
   logic            done_pls;

   int total;
   int bad;

   ga_init_pop_mc dut (
      .clk              (clk),
      .rstn             (rstn),
      .sw_rst           (sw_rst),
      .cnfg_p           (cnfg_p),
      .cnfg_m           (cnfg_m),
      .cnfg_mode        (cnfg_mode),
      .cnfg_seed_chrom  (cnfg_seed_chrom),
      .start_pls        (start_pls),
      .rand_data        (rand_data),
      .queue_ready      (queue_ready),
      .queue_push       (queue_push),
      .queue_chromosome (queue_chromosome),
      .busy             (busy),
      .done_pls         (done_pls)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         mode;
      int         p;
      int         m;
      logic [5:0] sw;
      bit         tog;
      int         chg_n;
      int         rst_at;
      int         budget;
      int         e_push;
      int         e_first;
      int         e_last;
      int         e_done;
   } vec_t;

   vec_t vecs[11];

   task automatic check(input string name, input logic [CW-1:0] act, input logic [CW-1:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h want %0h", name, act, exp);
      end
   endtask

   function automatic logic [CW-1:0] exp_chrom(input int mode, input int m,
                                               input logic [5:0] sw, input logic first);
      logic [CW-1:0] c;
      logic [5:0]    s;
      c = '0;
      for (int i = 0; i < 32; i++) begin
         if (i < m) begin
            s = rand_data[(i % 7)*6 +: 6];
            if (mode == 1 && first)  c[i*6 +: 6] = sw;
            else if (mode == 2)      c[i*6 +: 6] = sw ^ {4'b0000, s[1:0]};
            else                     c[i*6 +: 6] = s;
         end
      end
      return c;
   endfunction

   task automatic run_vec(input int idx, input vec_t v);
      int pushes;
      int first;
      int last;
      int done_at;
      int mc;
      logic [CW-1:0] exp;
      mc      = (v.m > 32) ? 32 : v.m;
      pushes  = 0;
      first   = 0;
      last    = 0;
      done_at = 0;
      @(negedge clk);
      cnfg_p          = 11'(v.p);
      cnfg_m          = 6'(v.m);
      cnfg_mode       = 2'(v.mode);
      cnfg_seed_chrom = {32{v.sw}};
      queue_ready     = 1'b1;
      start_pls       = 1'b1;
      @(posedge clk);
      #1 start_pls = 1'b0;
      for (int n = 1; n <= v.budget; n++) begin
         @(negedge clk);
         queue_ready = v.tog ? (n % 2 == 0) : 1'b1;
         if (n == v.chg_n) begin
            start_pls = 1'b1;
            cnfg_p    = 11'd5;
            cnfg_m    = 6'd0;
            cnfg_mode = 2'd2;
         end
         if (n == v.rst_at) sw_rst = 1'b1;
         #1;
         if (n == 1) check($sformatf("v%0d busy_start", idx), CW'(busy), CW'(v.p != 0));
         if (v.rst_at > 0 && n == v.rst_at + 1) begin
            check($sformatf("v%0d busy_after_swrst", idx), CW'(busy), '0);
            check($sformatf("v%0d chrom_after_swrst", idx), queue_chromosome, '0);
         end
         if (queue_push) begin
            exp = exp_chrom(v.mode, mc, v.sw, pushes == 0);
            check($sformatf("v%0d chrom_push%0d", idx, pushes), queue_chromosome, exp);
            if (pushes == 0) first = n;
            last = n;
            pushes++;
         end
         if (done_pls && done_at == 0) done_at = n;
         @(posedge clk);
         #1;
         start_pls = 1'b0;
         sw_rst    = 1'b0;
         if (done_at != 0) break;
      end
      check($sformatf("v%0d pushes", idx), CW'(pushes), CW'(v.e_push));
      check($sformatf("v%0d first_push_edge", idx), CW'(first), CW'(v.e_first));
      check($sformatf("v%0d last_push_edge", idx), CW'(last), CW'(v.e_last));
      check($sformatf("v%0d done_edge", idx), CW'(done_at), CW'(v.e_done));
      check($sformatf("v%0d done_single", idx), CW'(done_pls), '0);
      check($sformatf("v%0d busy_end", idx), CW'(busy), '0);
   endtask

   initial begin
      total           = 0;
      bad             = 0;
      clk             = 1'b0;
      rstn            = 1'b0;
      sw_rst          = 1'b0;
      cnfg_p          = '0;
      cnfg_m          = '0;
      cnfg_mode       = '0;
      cnfg_seed_chrom = '0;
      start_pls       = 1'b0;
      rand_data       = 42'h2B45C6DE7F1;
      queue_ready     = 1'b1;

      //            mode  p  m   sw   tog chg rst bud push first last done
      vecs[0]  = '{0, 16, 10, 6'h00, 1'b0, 0,  0, 60, 16, 3, 48, 49};
      vecs[1]  = '{1, 16, 10, 6'h3F, 1'b0, 0,  0, 60, 16, 1, 46, 47};
      vecs[2]  = '{2,  4, 10, 6'h2A, 1'b0, 0,  0, 30,  4, 3, 12, 13};
      vecs[3]  = '{0,  3, 10, 6'h00, 1'b1, 0,  0, 30,  3, 4, 12, 13};
      vecs[4]  = '{0,  0, 10, 6'h00, 1'b0, 0,  0, 30,  0, 0,  0,  1};
      vecs[5]  = '{0,  3,  0, 6'h00, 1'b0, 0,  0, 30,  3, 2,  6,  7};
      vecs[6]  = '{0,  2, 40, 6'h00, 1'b0, 0,  0, 30,  2, 6, 12, 13};
      vecs[7]  = '{3,  2,  7, 6'h00, 1'b0, 0,  0, 30,  2, 2,  4,  5};
      vecs[8]  = '{0,  2, 10, 6'h00, 1'b0, 2,  0, 30,  2, 3,  6,  7};
      vecs[9]  = '{0, 16, 10, 6'h00, 1'b0, 0, 13, 40,  4, 3, 12,  0};
      vecs[10] = '{0, 16, 10, 6'h00, 1'b0, 0,  0, 60, 16, 3, 48, 49};

      #7;
      check("reset queue_push", CW'(queue_push), '0);
      check("reset busy", CW'(busy), '0);
      check("reset done_pls", CW'(done_pls), '0);
      check("reset chromosome", queue_chromosome, '0);
      #5 rstn = 1'b1;

      for (int i = 0; i < 11; i++) begin
         run_vec(i, vecs[i]);
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/ga_init_pop_mc.md
Name: ga_init_pop_mc

Overview:
Second-generation initial-population generator for the GA accelerator. It builds cnfg_p chromosomes of cnfg_m weights each, using the shared random source, and pushes each one into the chromosome queue. Relative to the first generation it fills several weights per cycle (parametrised by RAND_W and DATA_W) and supports seeded and perturbed-seed modes. It honours queue back-pressure and reports busy/done to the GA top controller.

Parameters:
DATA_W, 6, width of one weight w_i
M_MAX, 32, maximum weights per chromosome
P_MAX, 1024, maximum individuals per population
RAND_W, 42, random input width; must be >= DATA_W
WPC, RAND_W/DATA_W (derived, integer division), weights filled per FILL cycle
P_MAX_W, $clog2(P_MAX+1), width of cnfg_p
M_MAX_W, $clog2(M_MAX+1), width of cnfg_m
CHROM_MAX_W, DATA_W*M_MAX, chromosome bus width

Ports:
clk  in  1  system clock, all logic on rising edge
rstn  in  1  asynchronous active-low reset
sw_rst  in  1  synchronous soft reset, active high
cnfg_p  in  P_MAX_W  population size
cnfg_m  in  M_MAX_W  weights per chromosome
cnfg_mode  in  2  0=random, 1=seed-first, 2=perturb-seed, 3=treated as 0
cnfg_seed_chrom  in  CHROM_MAX_W  seed chromosome for modes 1 and 2
start_pls  in  1  single-cycle start
rand_data  in  RAND_W  fresh random bits every cycle
queue_ready  in  1  queue can accept a push this cycle
queue_push  out  1  chromosome transfer strobe
queue_chromosome  out  CHROM_MAX_W  chromosome; weight i at bits [i*DATA_W +: DATA_W]
busy  out  1  generation in progress
done_pls  out  1  single-cycle pulse after the last push

Behaviour:
- Reset (rstn=0, async) and sw_rst (sync) have the same effect. State returns to IDLE. Counters clear. queue_chromosome, busy and done_pls go to 0. sw_rst takes priority over start_pls in the same cycle. A reset during FILL or PUSH aborts generation with no further push.
- Config is sampled on start_pls. cnfg_m above M_MAX is clamped to M_MAX. Config changes while busy have no effect.
- start_pls is ignored while busy=1.
- FSM has three states: IDLE, FILL, PUSH.
- IDLE + start_pls:
  - If cnfg_p==0: stay IDLE; done_pls=1 next cycle; no push.
  - If mode 1: load the seed (masked) into the chromosome register, go to PUSH.
  - Otherwise: clear the chromosome register and w_idx, go to FILL.
  - busy=1 from the next cycle until return to IDLE.
- FILL: each cycle writes weights w_idx..w_idx+WPC-1.
  - Slice k is rand_data[k*DATA_W +: DATA_W].
  - Mode 0/3 (and mode 1 after the first chromosome): weight = slice.
  - Mode 2: weight = seed weight XOR {zeros, slice[1:0]}.
  - Weights at index >= cnfg_m are forced to 0.
  - w_idx += WPC. Move to PUSH when w_idx+WPC >= cnfg_m. FILL lasts max(1, ceil(cnfg_m/WPC)) cycles; cnfg_m=0 gives one cycle and an all-zero chromosome.
- PUSH:
  - queue_push = (state==PUSH) & queue_ready (combinational).
  - queue_chromosome is registered and stable throughout PUSH.
  - If queue_ready=0: hold, no push.
  - On push: chrom_cnt++. If chrom_cnt was cnfg_p-1, go to IDLE, busy=0 and done_pls=1 in the next cycle. Otherwise clear the chromosome register and w_idx, go to FILL.
- Exactly cnfg_p pushes per start. No push outside PUSH.
- Throughput with queue_ready=1: one chromosome per (fill cycles + 1) cycles.

Test Plan:
- Mode 0, cnfg_p=16, cnfg_m=10, RAND_W=42 (WPC=7), queue_ready=1, start sampled at edge T -> pushes at edges T+3, T+6 … T+48 (16 total); bits [191:60] are 0; done_pls high for the single cycle ending at edge T+49; busy then 0.
- Mode 1, seed=all-ones, cnfg_m=10 -> first push at edge T+1 equals 60 ones with upper bits 0; remaining 15 chromosomes are random; 16 pushes total.
- Mode 2, seed weights=6'h2A, cnfg_p=4 -> every weight is in {2A,2B,28,29}; weights >= 10 are 0.
- Back-pressure: queue_ready toggles 0/1 each cycle -> no push while ready=0; chromosome stable across stalls; exactly cnfg_p pushes.
- sw_rst asserted mid-FILL on the 5th chromosome -> idle next cycle, no further push, no done_pls; a new start_pls produces a full 16 pushes.
- Corners:
  - cnfg_p=0 -> done_pls only.
  - cnfg_m=0 -> all-zero chromosomes every 2 cycles.
  - cnfg_m=40 -> clamped to 32.
  - start_pls while busy -> ignored.
